// File: rtl/button_pio_debounce_irq_if.sv
// Avalon-MM slave bus bundle for the debounced button PIO.
// The master drives the strobes, address and write data; the slave returns readdata.
interface button_pio_debounce_irq_if;
    logic        chipselect;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output address,
        output read,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/button_pio_debounce_irq.sv
// N-channel button input port: 2-flop synchroniser, per-channel debounce, edge capture with
// write-1-to-clear, maskable level IRQ, and an Avalon-MM register window.
module button_pio_debounce_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_MODE       = 0,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [WIDTH-1:0]                in_port,
    button_pio_debounce_irq_if.slave        bus,
    output logic                            irq
);

    localparam int unsigned      CntWidth = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] Released = {WIDTH{ACTIVE_LOW}};

    localparam logic [1:0] AddrData = 2'd0;
    localparam logic [1:0] AddrMask = 2'd2;
    localparam logic [1:0] AddrEdge = 2'd3;

    logic [WIDTH-1:0]    sync1_q, sync2_q;
    logic [WIDTH-1:0]    stable_q, stable_d;
    logic [CntWidth-1:0] cnt_q [WIDTH];
    logic [CntWidth-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]    prev_q;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [WIDTH-1:0]    edgecap_q, edgecap_d;
    logic [31:0]         readdata_q, rdata_d;
    logic                irq_q;

    logic [WIDTH-1:0]    pressed;
    logic [WIDTH-1:0]    edge_hit;
    logic [WIDTH-1:0]    w1c;
    logic                cs_wr, cs_rd;
    logic                unused_wdata;

    // Only the low WIDTH bits of writedata carry register content.
    assign unused_wdata = ^bus.writedata;

    assign cs_wr   = bus.chipselect & bus.write;
    assign cs_rd   = bus.chipselect & bus.read;
    assign pressed = stable_q ^ Released;

    // A channel accepts a new level only after DEBOUNCE_CYCLES consecutive disagreeing
    // samples; any return to the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        edge_hit = '0;
        if (EDGE_MODE == 32'd0) begin
            edge_hit = pressed & ~prev_q;
        end else if (EDGE_MODE == 32'd1) begin
            edge_hit = ~pressed & prev_q;
        end else begin
            edge_hit = pressed ^ prev_q;
        end
    end

    // A fresh edge overrides a same-cycle clear of that bit.
    always_comb begin
        w1c       = (cs_wr && bus.address == AddrEdge) ? bus.writedata[WIDTH-1:0] : '0;
        mask_d    = (cs_wr && bus.address == AddrMask) ? bus.writedata[WIDTH-1:0] : mask_q;
        edgecap_d = (edgecap_q & ~w1c) | edge_hit;
    end

    always_comb begin
        rdata_d = '0;
        case (bus.address)
            AddrData: rdata_d = 32'(pressed);
            AddrMask: rdata_d = 32'(mask_q);
            AddrEdge: rdata_d = 32'(edgecap_q);
            default:  rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= Released;
            sync2_q    <= Released;
            stable_q   <= Released;
            cnt_q      <= '{default: '0};
            prev_q     <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q   <= in_port;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            prev_q    <= pressed;
            mask_q    <= mask_d;
            edgecap_q <= edgecap_d;
            irq_q     <= |(edgecap_d & mask_d);
            if (cs_rd) begin
                readdata_q <= rdata_d;
            end
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule
